// File: rtl/bht_sat_table.sv
// Branch history table of 2-bit saturating counters with a valid bit per entry.
// One-cycle registered lookup, read-before-write against same-cycle training.
module bht_sat_table #(
  parameter int unsigned VLEN       = 32,
  parameter int unsigned NR_ENTRIES = 128
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            debug_mode_i,
  input  logic            lookup_valid_i,
  input  logic [VLEN-1:0] lookup_pc_i,
  input  logic            update_valid_i,
  input  logic [VLEN-1:0] update_pc_i,
  input  logic            update_taken_i,
  output logic            prediction_valid_o,
  output logic            prediction_taken_o
);

  localparam int unsigned IDX_W = $clog2(NR_ENTRIES);

  logic             valid_r [NR_ENTRIES];
  logic [1:0]       ctr_r   [NR_ENTRIES];
  logic             prediction_valid_r;
  logic             prediction_taken_r;
  logic [IDX_W-1:0] lookup_idx_s;
  logic [IDX_W-1:0] update_idx_s;
  logic             train_s;
  logic             unused_s;

  function automatic logic [1:0] sat_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    case ({taken, ctr})
      3'b1_11: nxt = 2'd3;
      3'b0_00: nxt = 2'd0;
      3'b1_00, 3'b1_01, 3'b1_10: nxt = ctr + 2'd1;
      3'b0_01, 3'b0_10, 3'b0_11: nxt = ctr - 2'd1;
      default: nxt = 2'd1;
    endcase
    return nxt;
  endfunction

  // Halfword-granular index; bit 0 and upper PC bits are deliberately dropped.
  assign lookup_idx_s = lookup_pc_i[IDX_W:1];
  assign update_idx_s = update_pc_i[IDX_W:1];
  assign train_s      = update_valid_i & ~debug_mode_i;
  assign unused_s     = ^{lookup_pc_i[VLEN-1:IDX_W+1], lookup_pc_i[0],
                          update_pc_i[VLEN-1:IDX_W+1], update_pc_i[0]};

  // Table storage: reset/flush to invalid weakly-not-taken, otherwise train.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        valid_r[i] <= 1'b0;
        ctr_r[i]   <= 2'd1;
      end
    end else if (flush_i) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        valid_r[i] <= 1'b0;
        ctr_r[i]   <= 2'd1;
      end
    end else if (train_s) begin
      valid_r[update_idx_s] <= 1'b1;
      ctr_r[update_idx_s]   <= sat_next(ctr_r[update_idx_s], update_taken_i);
    end
  end

  // Registered prediction sampled from the pre-update table contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prediction_valid_r <= 1'b0;
      prediction_taken_r <= 1'b0;
    end else if (flush_i || !lookup_valid_i) begin
      prediction_valid_r <= 1'b0;
      prediction_taken_r <= 1'b0;
    end else begin
      prediction_valid_r <= valid_r[lookup_idx_s];
      prediction_taken_r <= ctr_r[lookup_idx_s][1];
    end
  end

  assign prediction_valid_o = prediction_valid_r;
  assign prediction_taken_o = prediction_taken_r;

endmodule

// File: tb/tb_bht_sat_table.sv
// Directed bench for bht_sat_table: an arithmetic reference model checked every
// cycle, plus hand-computed expectations at key points of the sequence.
module tb_bht_sat_table;

  localparam int NR = 128;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        debug_mode_i = 1'b0;
  logic        lookup_valid_i = 1'b0;
  logic [31:0] lookup_pc_i = 32'h0;
  logic        update_valid_i = 1'b0;
  logic [31:0] update_pc_i = 32'h0;
  logic        update_taken_i = 1'b0;
  logic        prediction_valid_o;
  logic        prediction_taken_o;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  int mv [NR];
  int mc [NR];
  bit ev, et;

  bht_sat_table #(.VLEN(32), .NR_ENTRIES(NR)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .debug_mode_i(debug_mode_i),
    .lookup_valid_i(lookup_valid_i), .lookup_pc_i(lookup_pc_i),
    .update_valid_i(update_valid_i), .update_pc_i(update_pc_i),
    .update_taken_i(update_taken_i),
    .prediction_valid_o(prediction_valid_o), .prediction_taken_o(prediction_taken_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: entries as integers, counter moved by +/-1 clamped to 0..3.
  always @(posedge clk_i or negedge rst_ni) begin
    int li, ui, c;
    if (!rst_ni) begin
      for (int i = 0; i < NR; i++) begin mv[i] <= 0; mc[i] <= 1; end
      ev <= 1'b0; et <= 1'b0;
    end else begin
      li = int'((lookup_pc_i >> 1) % 32'(NR));
      ui = int'((update_pc_i >> 1) % 32'(NR));
      if (flush_i || !lookup_valid_i) begin
        ev <= 1'b0; et <= 1'b0;
      end else begin
        ev <= (mv[li] != 0);
        et <= (mc[li] >= 2);
      end
      if (flush_i) begin
        for (int i = 0; i < NR; i++) begin mv[i] <= 0; mc[i] <= 1; end
      end else if (update_valid_i && !debug_mode_i) begin
        c = update_taken_i ? mc[ui] + 1 : mc[ui] - 1;
        if (c > 3) c = 3;
        if (c < 0) c = 0;
        mv[ui] <= 1;
        mc[ui] <= c;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk_i) begin
    if (cmp_en) begin
      chk("model_valid", prediction_valid_o, ev);
      chk("model_taken", prediction_taken_o, et);
    end
  end

  task automatic step(input logic lv, input logic [31:0] lpc, input logic uv,
                      input logic [31:0] upc, input logic ut, input logic fl,
                      input logic dbg);
    lookup_valid_i = lv; lookup_pc_i = lpc;
    update_valid_i = uv; update_pc_i = upc; update_taken_i = ut;
    flush_i = fl; debug_mode_i = dbg;
    @(negedge clk_i);
  endtask

  task automatic upd(input logic [31:0] pc, input logic t);
    step(1'b0, 32'h0, 1'b1, pc, t, 1'b0, 1'b0);
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic v, input logic t);
    step(1'b1, pc, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk({name, "_v"}, prediction_valid_o, v);
    chk({name, "_t"}, prediction_taken_o, t);
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    chk("rst_v", prediction_valid_o, 1'b0);
    chk("rst_t", prediction_taken_o, 1'b0);
    rst_ni = 1'b1;
    cmp_en = 1'b1;

    look("cold", 32'h8000_0010, 1'b0, 1'b0);

    upd(32'h8000_0010, 1'b1);
    upd(32'h8000_0010, 1'b1);
    look("ctr3", 32'h8000_0010, 1'b1, 1'b1);
    upd(32'h8000_0010, 1'b1);
    look("sat3", 32'h8000_0010, 1'b1, 1'b1);
    upd(32'h8000_0010, 1'b0);
    look("ctr2", 32'h8000_0010, 1'b1, 1'b1);
    upd(32'h8000_0010, 1'b0);
    look("ctr1", 32'h8000_0010, 1'b1, 1'b0);
    upd(32'h8000_0010, 1'b0);
    upd(32'h8000_0010, 1'b0);
    look("sat0", 32'h8000_0010, 1'b1, 1'b0);
    upd(32'h8000_0010, 1'b1);

    step(1'b0, 32'h8000_0010, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("nolookup_v", prediction_valid_o, 1'b0);

    upd(32'h8000_0002, 1'b1);
    look("hw_hit", 32'h8000_0002, 1'b1, 1'b1);
    look("hw_miss", 32'h8000_0000, 1'b0, 1'b0);
    look("alias", 32'h8000_0102, 1'b1, 1'b1);

    upd(32'h8000_0020, 1'b1);
    upd(32'h8000_0022, 1'b0);
    look("b2b_a", 32'h8000_0020, 1'b1, 1'b1);
    look("b2b_b", 32'h8000_0022, 1'b1, 1'b0);

    step(1'b1, 32'h8000_0010, 1'b1, 32'h8000_0010, 1'b1, 1'b0, 1'b0);
    chk("rbw_v", prediction_valid_o, 1'b1);
    chk("rbw_t", prediction_taken_o, 1'b0);
    look("rbw_after", 32'h8000_0010, 1'b1, 1'b1);

    upd(32'h8000_0010, 1'b1);
    look("pre_flush", 32'h8000_0010, 1'b1, 1'b1);
    step(1'b1, 32'h8000_0010, 1'b1, 32'h8000_0010, 1'b1, 1'b1, 1'b0);
    chk("flush_v", prediction_valid_o, 1'b0);
    chk("flush_t", prediction_taken_o, 1'b0);
    look("post_flush", 32'h8000_0010, 1'b0, 1'b0);
    look("post_flush_b", 32'h8000_0002, 1'b0, 1'b0);
    upd(32'h8000_0010, 1'b1);
    look("flush_retrain", 32'h8000_0010, 1'b1, 1'b1);

    repeat (4) step(1'b0, 32'h0, 1'b1, 32'h8000_0040, 1'b1, 1'b0, 1'b1);
    look("debug", 32'h8000_0040, 1'b0, 1'b0);

    look("pre_rst", 32'h8000_0010, 1'b1, 1'b1);
    lookup_valid_i = 1'b1; lookup_pc_i = 32'h8000_0010;
    update_valid_i = 1'b1; update_pc_i = 32'h8000_0040; update_taken_i = 1'b1;
    #2 rst_ni = 1'b0;
    #1;
    chk("midrst_v", prediction_valid_o, 1'b0);
    chk("midrst_t", prediction_taken_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    look("rst_clear", 32'h8000_0010, 1'b0, 1'b0);
    look("rst_clear_b", 32'h8000_0040, 1'b0, 1'b0);
    upd(32'h8000_0010, 1'b1);
    look("rst_retrain", 32'h8000_0010, 1'b1, 1'b1);

    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bht_sat_table.md
BHT_SAT_TABLE -- requirements
Module: bht_sat_table

Interface
- REQ-001: Parameter VLEN, default 32, is the virtual PC width in bits.
- REQ-002: Parameter NR_ENTRIES, default 128, is the number of table entries; it SHALL be a power of two and at least 2.
- REQ-003: Let IDX_W = log2(NR_ENTRIES).
- REQ-004: There SHALL be one clock; reset is asynchronous and active-low.
- REQ-005: Ports SHALL be as follows:
  - clk_i  in  1  clock
  - rst_ni  in  1  asynchronous active-low reset
  - flush_i  in  1  clear entire table
  - debug_mode_i  in  1  core in debug mode; blocks training
  - lookup_valid_i  in  1  lookup request
  - lookup_pc_i  in  VLEN  PC to predict
  - update_valid_i  in  1  resolved conditional branch
  - update_pc_i  in  VLEN  PC of resolved branch
  - update_taken_i  in  1  resolved direction
  - prediction_valid_o  out  1  registered prediction is meaningful
  - prediction_taken_o  out  1  registered predicted direction

Function
- REQ-006: Each entry SHALL hold 1 valid bit and a 2-bit saturating counter.
- REQ-007: Entry index SHALL be pc[IDX_W:1]. Bit 0 is ignored, so compressed halfword-aligned PCs map to distinct entries. Upper PC bits are ignored, so aliasing is permitted.
- REQ-008: Lookup latency SHALL be exactly 1 cycle.
  - prediction_valid_o = registered (lookup_valid_i AND entry.valid).
  - prediction_taken_o = registered entry.counter[1].
- REQ-009: When lookup_valid_i = 0, the next cycle SHALL show prediction_valid_o = 0 and prediction_taken_o = 0.
- REQ-010: On update_valid_i = 1 with debug_mode_i = 0 and flush_i = 0, the indexed entry SHALL, at the next clock edge:
  - set valid = 1;
  - if taken and counter != 3, increment the counter;
  - if not taken and counter != 0, decrement the counter.
- REQ-011: Counters SHALL saturate: taken at 3 stays 3; not-taken at 0 stays 0; no wrap-around.
- REQ-012: Training on a previously invalid entry SHALL apply REQ-010 to its stored counter, which is 1 after reset or flush.
- REQ-013: update_valid_i with debug_mode_i = 1 SHALL leave the table unchanged.
- REQ-014: Lookup and update to the same index in the same cycle SHALL be read-before-write. The prediction reflects the pre-update entry; the update still commits.
- REQ-015: flush_i = 1 SHALL, at the next edge, set every entry to valid = 0, counter = 1.
- REQ-016: flush_i SHALL take priority over a same-cycle update; the update is discarded.
- REQ-017: flush_i = 1 SHALL force prediction_valid_o = 0 and prediction_taken_o = 0 in the following cycle, regardless of lookup_valid_i.
- REQ-018: Lookups and updates SHALL be accepted every cycle, with no back-pressure.
- REQ-019: Updates to different indices in consecutive cycles SHALL each commit independently.

Reset
- REQ-020: While rst_ni = 0, asynchronously:
  - every entry SHALL be valid = 0, counter = 1;
  - prediction_valid_o = 0 and prediction_taken_o = 0.
- REQ-021: Reset asserted mid-operation SHALL discard any in-flight lookup result and any same-cycle update.
- REQ-022: After reset release, the first lookup SHALL return prediction_valid_o = 0.

Verification
- REQ-023: Cold lookup. After reset, lookup pc 0x8000_0010 -> next cycle valid = 0, taken = 0.
- REQ-024: Training and saturation.
  - Two taken updates to 0x8000_0010, then lookup -> valid = 1, taken = 1 (counter 3).
  - A third taken update leaves the counter at 3.
  - One not-taken update -> counter 2, still predicts taken.
  - A second not-taken update -> counter 1, predicts not-taken.
- REQ-025: Halfword indexing and aliasing (NR_ENTRIES = 128).
  - Taken update to 0x8000_0002 -> lookup 0x8000_0002 gives valid = 1; lookup 0x8000_0000 gives valid = 0.
  - Lookup 0x8000_0102 (same index) gives valid = 1, taken = 1 (counter 2).
- REQ-026: Same-cycle lookup and update.
  - Entry at counter 1, valid: lookup plus taken update in the same cycle -> prediction taken = 0.
  - Lookup the next cycle -> taken = 1.
- REQ-027: Flush priority.
  - Train an entry to 3, then assert flush_i with a same-cycle taken update and lookup -> next cycle prediction_valid_o = 0.
  - Subsequent lookup -> valid = 0.
  - A single taken update afterwards -> counter 2, taken = 1.
- REQ-028: Debug mode and reset.
  - With debug_mode_i = 1, four taken updates to a fresh entry -> lookup valid = 0.
  - Asserting rst_ni low for one cycle mid-lookup -> outputs 0 immediately and table cleared.
